bp_two_fifo_ctrl_width_p131: RTL and testbench

// - Two-entry ready/valid FIFO controller that sits directly upstream of the 2-element x 131-bit 1r1w synth memory and drives it.
// - Accepts producer data (valid/ready handshake), issues the memory write, and steers the memory read address.
// - Presents the head entry to the consumer (valid/yumi handshake).
// - Used wherever the multi-core top needs a 2-deep decoupling buffer on 131-bit payloads.

---
 rtl/bp_two_fifo_ctrl_width_p131_if.sv | 30 +++
 rtl/bp_two_fifo_ctrl_width_p131.sv | 93 +++++++++
 tb/tb_bp_two_fifo_ctrl_width_p131.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_two_fifo_ctrl_width_p131_if.sv
// Producer/consumer handshake bundle for the two-entry FIFO controller.
// The slave modport is the FIFO side; the master modport is the environment side.
interface bp_two_fifo_ctrl_width_p131_if #(
    parameter int width_p = 131
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;

    modport slave (
        input  v_i,
        input  data_i,
        output ready_o,
        output v_o,
        output data_o,
        input  yumi_i
    );

    modport master (
        output v_i,
        output data_i,
        input  ready_o,
        input  v_o,
        input  data_o,
        output yumi_i
    );
endinterface

// File: rtl/bp_two_fifo_ctrl_width_p131.sv
// Two-entry ready/valid FIFO controller driving an external 2x width_p 1r1w memory.
// Optional sticky protocol checker enabled by defining BP_TWO_FIFO_ERR_CHECK_EN.
module bp_two_fifo_ctrl_width_p131 #(
    parameter int width_p = 131,
    parameter int els_p   = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    bp_two_fifo_ctrl_width_p131_if.slave fifo_if,
    output logic [1:0]           count_o,
    output logic                 mem_w_v_o,
    output logic                 mem_w_addr_o,
    output logic [width_p-1:0]   mem_w_data_o,
    output logic                 mem_r_v_o,
    output logic                 mem_r_addr_o,
    input  logic [width_p-1:0]   mem_r_data_i,
    output logic                 err_o
);

    if (els_p != 2) begin : g_bad_els
        $error("bp_two_fifo_ctrl_width_p131 supports only els_p == 2");
    end

    logic wptr_r;
    logic rptr_r;
    logic full_r;
    logic empty_r;
    logic enq;
    logic deq;

    // No pass-through when full: ready depends only on registered state and reset.
    assign fifo_if.ready_o = ~full_r & ~reset_i;
    assign fifo_if.v_o     = ~empty_r;
    assign fifo_if.data_o  = mem_r_data_i;

    assign enq = fifo_if.v_i    & fifo_if.ready_o;
    assign deq = fifo_if.yumi_i & fifo_if.v_o;

    assign mem_w_v_o    = enq;
    assign mem_w_addr_o = wptr_r;
    assign mem_w_data_o = fifo_if.data_i;
    assign mem_r_v_o    = fifo_if.v_o;
    assign mem_r_addr_o = rptr_r;

    assign count_o = full_r ? 2'd2 : (empty_r ? 2'd0 : 2'd1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            unique case ({enq, deq})
                2'b10: begin
                    wptr_r  <= ~wptr_r;
                    empty_r <= 1'b0;
                    full_r  <= (~wptr_r == rptr_r);
                end
                2'b01: begin
                    rptr_r  <= ~rptr_r;
                    full_r  <= 1'b0;
                    empty_r <= (~rptr_r == wptr_r);
                end
                2'b11: begin
                    // Occupancy is unchanged, so full/empty hold.
                    wptr_r <= ~wptr_r;
                    rptr_r <= ~rptr_r;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BP_TWO_FIFO_ERR_CHECK_EN
    logic err_r;

    // Sticky: underflow (yumi with nothing valid) or overflow attempt (valid while full).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_r <= 1'b0;
        end else if ((fifo_if.yumi_i & ~fifo_if.v_o) | (fifo_if.v_i & full_r)) begin
            err_r <= 1'b1;
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_two_fifo_ctrl_width_p131.sv
// Scoreboard bench for the two-entry FIFO controller with a behavioural 2x131 async-read memory.
module tb_bp_two_fifo_ctrl_width_p131;

    localparam int W = 131;

    logic         clk;
    logic         reset_i;
    logic [1:0]   count_o;
    logic         mem_w_v_o;
    logic         mem_w_addr_o;
    logic [W-1:0] mem_w_data_o;
    logic         mem_r_v_o;
    logic         mem_r_addr_o;
    logic [W-1:0] mem_r_data_i;
    logic         err_o;
    logic [W-1:0] mem [2];

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_data_q [$];
    logic         exp_addr_q [$];
    logic         wexp;

    bp_two_fifo_ctrl_width_p131_if #(.width_p(W)) fif ();

    bp_two_fifo_ctrl_width_p131 #(.width_p(W), .els_p(2)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .fifo_if      (fif.slave),
        .count_o      (count_o),
        .mem_w_v_o    (mem_w_v_o),
        .mem_w_addr_o (mem_w_addr_o),
        .mem_w_data_o (mem_w_data_o),
        .mem_r_v_o    (mem_r_v_o),
        .mem_r_addr_o (mem_r_addr_o),
        .mem_r_data_i (mem_r_data_i),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_w_v_o) mem[mem_w_addr_o] <= mem_w_data_o;
    assign mem_r_data_i = mem[mem_r_addr_o];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every dequeue and every memory write.
    always @(negedge clk) begin
        if (!reset_i && fif.v_o && fif.yumi_i) begin
            if (exp_data_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL deq_unexpected: got %0h, expected no dequeue", fif.data_o);
            end else begin
                check("deq_data", fif.data_o, exp_data_q.pop_front());
            end
        end
        if (mem_w_v_o) begin
            if (exp_addr_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL wr_unexpected: got addr %0d, expected no write", mem_w_addr_o);
            end else begin
                check("wr_addr", {{(W-1){1'b0}}, mem_w_addr_o}, {{(W-1){1'b0}}, exp_addr_q.pop_front()});
            end
        end
    end

    // One cycle with given inputs; push expectations when an enqueue is intended.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic y, input logic expect_enq);
        fif.v_i    = v;
        fif.data_i = d;
        fif.yumi_i = y;
        if (expect_enq) begin
            exp_data_q.push_back(d);
            exp_addr_q.push_back(wexp);
            wexp = ~wexp;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        fif.v_i = 1'b0; fif.yumi_i = 1'b0;
        #1;
        check("ready_in_reset", {{(W-1){1'b0}}, fif.ready_o}, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        exp_data_q.delete();
        exp_addr_q.delete();
        wexp = 1'b0;
        #1;
    endtask

    localparam logic [W-1:0] A = 131'h1;
    localparam logic [W-1:0] B = 131'h2;
    localparam logic [W-1:0] C = 131'h3;

    initial begin
        reset_i = 1'b1;
        fif.v_i = 1'b0; fif.data_i = '0; fif.yumi_i = 1'b0;
        wexp = 1'b0;
        @(posedge clk); #1;
        do_reset();

        check("idle_v_o", {{(W-1){1'b0}}, fif.v_o}, '0);
        check("idle_ready", {{(W-1){1'b0}}, fif.ready_o}, 131'd1);
        check("idle_count", {{(W-2){1'b0}}, count_o}, '0);
        check("idle_mem_w_v", {{(W-1){1'b0}}, mem_w_v_o}, '0);
        check("idle_err", {{(W-1){1'b0}}, err_o}, '0);

        // Fill with A then B
        cyc(1'b1, A, 1'b0, 1'b1);
        check("cnt_after_A", {{(W-2){1'b0}}, count_o}, 131'd1);
        check("head_A", fif.data_o, A);
        cyc(1'b1, B, 1'b0, 1'b1);
        check("cnt_full", {{(W-2){1'b0}}, count_o}, 131'd2);
        check("ready_full", {{(W-1){1'b0}}, fif.ready_o}, '0);
        check("head_still_A", fif.data_o, A);

        // Drain
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("cnt_drain1", {{(W-2){1'b0}}, count_o}, 131'd1);
        check("head_B", fif.data_o, B);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("cnt_drain0", {{(W-2){1'b0}}, count_o}, '0);
        check("v_o_empty", {{(W-1){1'b0}}, fif.v_o}, '0);
        check("rptr_wrap", {{(W-1){1'b0}}, mem_r_addr_o}, '0);

        // Simultaneous enq+deq at count 1
        cyc(1'b1, A, 1'b0, 1'b1);
        cyc(1'b1, B, 1'b1, 1'b1);
        check("cnt_simul", {{(W-2){1'b0}}, count_o}, 131'd1);
        check("head_B_simul", fif.data_o, B);
        cyc(1'b1, C, 1'b1, 1'b1);
        check("head_C_simul", fif.data_o, C);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 131'h100 + W'(i), 1'b1, 1'b1);
            check("cnt_stream", {{(W-2){1'b0}}, count_o}, 131'd1);
        end
        check("head_stream_last", fif.data_o, 131'h107);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("cnt_stream_drained", {{(W-2){1'b0}}, count_o}, '0);

        // Reset while full
        cyc(1'b1, 131'hAAAA, 1'b0, 1'b1);
        cyc(1'b1, 131'hBBBB, 1'b0, 1'b1);
        check("cnt_full2", {{(W-2){1'b0}}, count_o}, 131'd2);
        do_reset();
        check("rst_v_o", {{(W-1){1'b0}}, fif.v_o}, '0);
        check("rst_count", {{(W-2){1'b0}}, count_o}, '0);
        check("rst_ready", {{(W-1){1'b0}}, fif.ready_o}, 131'd1);
        check("rst_err", {{(W-1){1'b0}}, err_o}, '0);

        // Underflow attempt
        cyc(1'b0, '0, 1'b1, 1'b0);
        fif.yumi_i = 1'b0;
`ifdef BP_TWO_FIFO_ERR_CHECK_EN
        check("err_underflow", {{(W-1){1'b0}}, err_o}, 131'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("err_sticky", {{(W-1){1'b0}}, err_o}, 131'd1);
`else
        check("err_underflow_off", {{(W-1){1'b0}}, err_o}, '0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("err_sticky_off", {{(W-1){1'b0}}, err_o}, '0);
`endif
        check("cnt_after_underflow", {{(W-2){1'b0}}, count_o}, '0);
        do_reset();
        check("err_cleared", {{(W-1){1'b0}}, err_o}, '0);

        // Overflow attempt: data dropped, state unchanged
        cyc(1'b1, 131'h11, 1'b0, 1'b1);
        cyc(1'b1, 131'h22, 1'b0, 1'b1);
        cyc(1'b1, 131'h33, 1'b0, 1'b0);
        check("cnt_overflow", {{(W-2){1'b0}}, count_o}, 131'd2);
        check("head_overflow", fif.data_o, 131'h11);
`ifdef BP_TWO_FIFO_ERR_CHECK_EN
        check("err_overflow", {{(W-1){1'b0}}, err_o}, 131'd1);
`else
        check("err_overflow_off", {{(W-1){1'b0}}, err_o}, '0);
`endif
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        fif.yumi_i = 1'b0;
        check("cnt_final", {{(W-2){1'b0}}, count_o}, '0);

        tests++;
        if (exp_data_q.size() != 0 || exp_addr_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d data / %0d addr pending, expected 0", exp_data_q.size(), exp_addr_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
